// File: rtl/sdram_avalon_arbiter_pkg.sv
// Package for the SDRAM Avalon arbiter.
// It pulls in the shared subsystem widths from sdram_params.svh and adds a
// helper function for round-robin pointer advance.
package sdram_avalon_arbiter_pkg;

  `include "sdram_params.svh"

  // Returns the next index after idx, counting modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sdram_fifo.sv
// Small synchronous FIFO. It has a first-word-fall-through head output.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   push, push_data - write one entry (ignored while full)
//   pop             - discard the head entry (ignored while empty)
//   head            - current head entry, valid while !empty
//   empty, full     - decoded from the registered occupancy
//
// DEPTH must be a power of two so that the pointers wrap naturally.
module sdram_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage holds data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_params.svh
// Shared SDRAM subsystem widths and queue sizes.
//
// Included once, inside sdram_avalon_arbiter_pkg. Everything that needs
// these values imports that package rather than re-declaring widths.
//
// Integration rule for sdram_avalon_arbiter:
//   TAG_DEPTH >= CMD_FIFO_SIZE + READ_FIFO_SIZE + 2
// The arbiter must be able to hold a tag for every read that can be in
// flight between its own port and the response path. That means every
// command queued in the controller, plus every word parked in its read
// FIFO, plus one read in the SDRAM pipeline and one on the response bus.
// With the defaults below, 2 + 4 + 2 = 8 matches the arbiter default.

localparam int AVS_AW         = 24;         // word address width
localparam int AVS_DW         = 16;         // data width
localparam int AVS_BYTE       = AVS_DW / 8; // byte-enable width
localparam int CMD_FIFO_SIZE  = 2;          // controller command queue depth
localparam int READ_FIFO_SIZE = 4;          // controller read-return queue depth

// File: rtl/sdram_avalon_arbiter.sv
// Round-robin arbiter that lets NUM_PORT Avalon-MM masters share one SDRAM
// controller slave.
//
// Ports:
//   clk, reset                      - single clock, synchronous active-high reset
//   m_read/m_write/m_address/
//   m_writedata/m_byteenable        - per-master requests, port i at slice i
//   m_waitrequest                   - per-master stall (low only for the accepted port)
//   m_readdata, m_readdatavalid     - shared read data, per-master valid
//   s_read/s_write/s_address/
//   s_writedata/s_byteenable        - request forwarded to the controller, zero latency
//   s_waitrequest                   - controller stall
//   s_readdata, s_readdatavalid     - controller read response
//   err_orphan                      - sticky: a response arrived with no tag outstanding
//
// The controller returns read data in order. For each accepted read, the
// index of the requesting port goes into a tag FIFO. The head tag then
// steers each response back to the port that asked for it.
module sdram_avalon_arbiter
  import sdram_avalon_arbiter_pkg::*;
#(
  parameter int NUM_PORT  = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORT-1:0]          m_read,
  input  logic [NUM_PORT-1:0]          m_write,
  input  logic [NUM_PORT*AVS_AW-1:0]   m_address,
  input  logic [NUM_PORT*AVS_DW-1:0]   m_writedata,
  input  logic [NUM_PORT*AVS_BYTE-1:0] m_byteenable,
  output logic [NUM_PORT-1:0]          m_waitrequest,
  output logic [AVS_DW-1:0]            m_readdata,
  output logic [NUM_PORT-1:0]          m_readdatavalid,
  output logic                         s_read,
  output logic                         s_write,
  output logic [AVS_AW-1:0]            s_address,
  output logic [AVS_DW-1:0]            s_writedata,
  output logic [AVS_BYTE-1:0]          s_byteenable,
  input  logic                         s_waitrequest,
  input  logic [AVS_DW-1:0]            s_readdata,
  input  logic                         s_readdatavalid,
  output logic                         err_orphan
);

  localparam int TW    = $clog2(NUM_PORT);
  localparam int TAG_W = (TW > 1) ? TW : 1;

  logic [NUM_PORT-1:0] elig;
  logic                gnt_vld;
  logic [TW-1:0]       gnt_idx;
  logic [TW-1:0]       cand;
  logic                accept;
  logic                tag_push, tag_pop, tag_empty, tag_full;
  logic [TAG_W-1:0]    tag_head;

  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic          err_orphan_q, err_orphan_d;

  // A read can only be granted if a tag slot is free. The check uses the
  // registered occupancy, so a pop in the same cycle does not unblock it.
  // Writes need no tag and so are never blocked.
  assign elig = (m_read | m_write) & ~(m_read & {NUM_PORT{tag_full}});

  // Grant selection. A port that was stalled by the controller keeps the
  // grant until it is accepted. Otherwise, search upward from rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (lock_q && elig[lock_idx_q]) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_PORT; k++) begin
        cand = TW'((int'(rr_ptr_q) + k) % NUM_PORT);
        if (!gnt_vld && elig[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // Zero-latency forwarding. When there is no grant, gnt_idx is 0, so the
  // data lines carry port 0. A read on the same port as a write takes priority.
  assign s_read       = gnt_vld & m_read[gnt_idx];
  assign s_write      = gnt_vld & m_write[gnt_idx] & ~m_read[gnt_idx];
  assign s_address    = m_address[int'(gnt_idx)*AVS_AW +: AVS_AW];
  assign s_writedata  = m_writedata[int'(gnt_idx)*AVS_DW +: AVS_DW];
  assign s_byteenable = m_byteenable[int'(gnt_idx)*AVS_BYTE +: AVS_BYTE];

  assign accept   = gnt_vld & ~s_waitrequest;
  assign tag_push = accept & m_read[gnt_idx];
  assign tag_pop  = s_readdatavalid & ~tag_empty;

  always_comb begin
    m_waitrequest = '1;
    if (accept) m_waitrequest[gnt_idx] = 1'b0;
  end

  always_comb begin
    m_readdatavalid = '0;
    if (tag_pop) m_readdatavalid[tag_head] = 1'b1;
  end

  assign m_readdata = s_readdata;
  assign err_orphan = err_orphan_q;

  always_comb begin
    rr_ptr_d     = accept ? TW'(rr_next(int'(gnt_idx), NUM_PORT)) : rr_ptr_q;
    lock_d       = gnt_vld & s_waitrequest;
    lock_idx_d   = gnt_idx;
    err_orphan_d = err_orphan_q | (s_readdatavalid & tag_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  sdram_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data (TAG_W'(gnt_idx)),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full)
  );

endmodule

// File: doc/sdram_avalon_arbiter.md
SDRAM_AVALON_ARBITER -- requirements
Module: sdram_avalon_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_PORT, default 2, number of Avalon masters (2..4).
- TAG_DEPTH, default 8, outstanding-read tag FIFO depth (power of 2).
REQ-002 SHALL have ports, one per line (P = NUM_PORT, TW = $clog2(NUM_PORT)):
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- m_read  input  P  per-port read request.
- m_write  input  P  per-port write request.
- m_address  input  P*AVS_AW  per-port address, port i at slice i.
- m_writedata  input  P*AVS_DW  per-port write data.
- m_byteenable  input  P*AVS_BYTE  per-port byte enables.
- m_waitrequest  output  P  per-port stall.
- m_readdata  output  AVS_DW  read data, shared by all ports.
- m_readdatavalid  output  P  per-port read data valid.
- s_read, s_write  output  1  request to the SDRAM controller.
- s_address  output  AVS_AW  controller address.
- s_writedata  output  AVS_DW  controller write data.
- s_byteenable  output  AVS_BYTE  controller byte enables.
- s_waitrequest  input  1  controller stall.
- s_readdata  input  AVS_DW  controller read data.
- s_readdatavalid  input  1  controller read valid.
- err_orphan  output  1  sticky flag: read data arrived with no tag outstanding.
REQ-003 Clock is clk; reset is synchronous, active-high, named reset.

Function
REQ-004 Port i is requesting when m_read[i] | m_write[i]; m_read and m_write on the same port at once is illegal, and read SHALL win.
REQ-005 Arbitration SHALL be round-robin.
- rr_ptr (TW bits) names the highest-priority port.
- The grant is the first requesting, eligible port, searching upward from rr_ptr with wrap-around.
REQ-006 A port with a read request is ineligible while the tag FIFO is full; a port with a write request stays eligible.
REQ-007 Granted request SHALL pass combinationally to s_* the same cycle (zero latency).
- With no grant: s_read = s_write = 0, and s_address/s_writedata/s_byteenable are driven from port 0.
REQ-008 Accept = grant & ~s_waitrequest. On accept, rr_ptr <= (granted index + 1) mod NUM_PORT.
REQ-009 Lock: if a grant is presented while s_waitrequest = 1, the grant SHALL be held to that port next cycle, even if a higher-priority port requests. The lock clears on accept.
REQ-010 m_waitrequest[i] SHALL be 0 only for the granted port when s_waitrequest = 0; it is 1 for every other port, and for all ports while s_waitrequest = 1.
REQ-011 On an accepted read, the granted index SHALL be pushed into the tag FIFO.
REQ-012 On s_readdatavalid = 1 with the tag FIFO non-empty:
- pop the head tag;
- assert m_readdatavalid[head] for exactly that cycle;
- m_readdata = s_readdata (combinational).
Responses SHALL return in request order.
REQ-013 On s_readdatavalid = 1 with the tag FIFO empty:
- no m_readdatavalid is asserted;
- err_orphan <= 1 and stays set until reset.
REQ-014 Push and pop in the same cycle SHALL both take effect and leave occupancy unchanged.
- Fullness for REQ-006 uses the registered occupancy, so a pop in the same cycle does not unblock a read.
REQ-015 Writes generate no tag and no response.

Reset
REQ-016 On reset, all of the following SHALL hold on the next cycle:
- rr_ptr = 0, lock cleared, tag FIFO empty, err_orphan = 0;
- m_readdatavalid = 0, and s_read/s_write follow REQ-007.
REQ-017 Reset mid-operation SHALL discard outstanding tags; responses arriving after reset set err_orphan per REQ-013.

Structure
REQ-018 AVS_AW, AVS_DW and AVS_BYTE SHALL come from the shared sdram_params.svh; no new widths are defined locally.
REQ-019 The tag FIFO SHALL be one instance of the existing sdram_fifo (WIDTH = max(TW,1), DEPTH = TAG_DEPTH); there are no other sub-modules.
REQ-020 The integration rule TAG_DEPTH >= CMD_FIFO_SIZE + READ_FIFO_SIZE + 2 SHALL be documented in sdram_params.svh.

Verification
REQ-021 Contention: port0 and port1 write continuously, s_waitrequest = 0 -> accepts alternate 0,1,0,1; s_address matches the granted port each cycle.
REQ-022 Lock: port1 reads 0x100 with s_waitrequest = 1 for 3 cycles while port0 (rr_ptr = 0) requests -> s_address stays 0x100 and m_waitrequest = 2'b11 for 3 cycles; port1 is accepted on cycle 4.
REQ-023 Routing:
- reads accepted in order p1, p0, p1;
- controller returns 0xAAAA, 0xBBBB, 0xCCCC;
- required: m_readdatavalid = 2'b10, 2'b01, 2'b10 respectively, with matching m_readdata.
REQ-024 Tag full: 8 reads accepted with no responses -> the ninth read stalls (m_waitrequest = 1) while a write on the other port is still accepted; one response unblocks the read the following cycle.
REQ-025 Orphan: s_readdatavalid = 1 with no outstanding read -> all m_readdatavalid = 0 and err_orphan = 1, held until reset.
REQ-026 Reset with 3 tags outstanding -> after reset the FIFO is empty and rr_ptr = 0; a late response sets err_orphan.
